// File: rtl/fwd_scoreboard_unit.sv
// rtl/fwd_scoreboard_unit.sv - superscalar operand-forward scoreboard with load-use and split-issue control
//
// Purpose: tracks destination tags of instructions issued into the pipeline
// and produces registered forward selects aligned with the bundle in EX. It
// also detects load-use and intra-bundle RAW hazards and issues an in-order
// prefix of the bundle.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   id_valid/rs/rt/rd      per-lane ID-stage instruction fields (lane i at [i*RB +: RB])
//   id_regwrite/memread    lane writes rd / lane is a load
//   pipe_hold              freeze tracker and EX outputs, block issue
//   flush                  squash the bundle issuing this cycle
//   issue_ok, stall        combinational issue mask and hazard stall
//   ex_valid, ex_fwd_a/b   registered per-lane EX valid and forward selects
//                          (0 = register file, else (s-1)*LANES + l + 1)

module fwd_scoreboard_unit #(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int RB     = 5,
  localparam int SW    = $clog2((STAGES-1)*LANES+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      id_valid,
  input  logic [LANES*RB-1:0]   id_rs,
  input  logic [LANES*RB-1:0]   id_rt,
  input  logic [LANES*RB-1:0]   id_rd,
  input  logic [LANES-1:0]      id_regwrite,
  input  logic [LANES-1:0]      id_memread,
  input  logic                  pipe_hold,
  input  logic                  flush,
  output logic [LANES-1:0]      issue_ok,
  output logic                  stall,
  output logic [LANES-1:0]      ex_valid,
  output logic [LANES*SW-1:0]   ex_fwd_a,
  output logic [LANES*SW-1:0]   ex_fwd_b
);

  // Only T1..T[STAGES-1] are stored: the last stage writes a write-first
  // register file, so its tags would never be looked at.
  localparam int NS = STAGES - 1;

  logic [NS-1:0][LANES-1:0]         r_t_valid;
  logic [NS-1:0][LANES-1:0][RB-1:0] r_t_rd;
  logic [NS-1:0][LANES-1:0]         r_t_load;

  logic [LANES-1:0]                 r_ex_valid;
  logic [LANES-1:0][SW-1:0]         r_ex_fwd_a;
  logic [LANES-1:0][SW-1:0]         r_ex_fwd_b;

  logic [LANES-1:0]                 w_hazard;
  logic [LANES-1:0]                 w_blocked;
  logic [LANES-1:0]                 w_issue;
  logic                             w_stall;
  logic [LANES-1:0][SW-1:0]         w_code_a;
  logic [LANES-1:0][SW-1:0]         w_code_b;

  function automatic logic f_match(input logic [RB-1:0] src, input logic [RB-1:0] rd);
    return (src != '0) && (src == rd);
  endfunction

  always_comb begin
    w_hazard = '0;
    w_code_a = '0;
    w_code_b = '0;
    for (int i = 0; i < LANES; i++) begin
      // Walk from oldest stage / oldest lane to youngest so the last hit
      // wins: lowest stage first, highest lane within a stage.
      for (int s = NS - 1; s >= 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (r_t_valid[s][l] && f_match(id_rs[i*RB +: RB], r_t_rd[s][l]))
            w_code_a[i] = SW'(s*LANES + l + 1);
          if (r_t_valid[s][l] && f_match(id_rt[i*RB +: RB], r_t_rd[s][l]))
            w_code_b[i] = SW'(s*LANES + l + 1);
        end
      end
      // Load-use: the load's data is not available until it leaves T1.
      for (int l = 0; l < LANES; l++) begin
        if (r_t_valid[0][l] && r_t_load[0][l] &&
            (f_match(id_rs[i*RB +: RB], r_t_rd[0][l]) ||
             f_match(id_rt[i*RB +: RB], r_t_rd[0][l])))
          w_hazard[i] = id_valid[i];
      end
      // Intra-bundle RAW against any older lane writing a register.
      for (int j = 0; j < i; j++) begin
        if (id_valid[j] && id_regwrite[j] && (id_rd[j*RB +: RB] != '0) &&
            (f_match(id_rs[i*RB +: RB], id_rd[j*RB +: RB]) ||
             f_match(id_rt[i*RB +: RB], id_rd[j*RB +: RB])))
          w_hazard[i] = id_valid[i];
      end
    end
  end

  // A hazard in any older lane blocks every younger lane (in-order prefix).
  always_comb begin
    w_blocked = '0;
    w_issue   = '0;
    w_stall   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_blocked[i] = w_hazard[i] | ((i == 0) ? 1'b0 : w_blocked[i-1]);
      w_issue[i]   = id_valid[i] & ~pipe_hold & ~w_blocked[i];
      w_stall      = w_stall | (id_valid[i] & w_blocked[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t_valid  <= '0;
      r_t_rd     <= '0;
      r_t_load   <= '0;
      r_ex_valid <= '0;
      r_ex_fwd_a <= '0;
      r_ex_fwd_b <= '0;
    end else if (!pipe_hold) begin
      for (int s = NS - 1; s >= 1; s--) begin
        r_t_valid[s] <= r_t_valid[s-1];
        r_t_rd[s]    <= r_t_rd[s-1];
        r_t_load[s]  <= r_t_load[s-1];
      end
      for (int l = 0; l < LANES; l++) begin
        r_t_valid[0][l]  <= w_issue[l] & ~flush & id_regwrite[l] & (id_rd[l*RB +: RB] != '0);
        r_t_rd[0][l]     <= id_rd[l*RB +: RB];
        r_t_load[0][l]   <= id_memread[l];
        r_ex_valid[l]    <= w_issue[l] & ~flush;
        // Squashed or unissued lanes carry a neutral select into EX.
        r_ex_fwd_a[l]    <= (w_issue[l] && !flush) ? w_code_a[l] : '0;
        r_ex_fwd_b[l]    <= (w_issue[l] && !flush) ? w_code_b[l] : '0;
      end
    end
  end

  assign issue_ok = w_issue;
  assign stall    = w_stall;
  assign ex_valid = r_ex_valid;
  assign ex_fwd_a = r_ex_fwd_a;
  assign ex_fwd_b = r_ex_fwd_b;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// tb/tb_fwd_scoreboard_unit.sv - self-checking bench for fwd_scoreboard_unit (LANES=2, STAGES=3)

module tb_fwd_scoreboard_unit;

  localparam int LANES = 2;
  localparam int RB    = 5;
  localparam int SW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [1:0]          v, rw, mr;
  logic [4:0]          rs [2];
  logic [4:0]          rt [2];
  logic [4:0]          rd [2];
  logic                pipe_hold, flush;
  logic [1:0]          issue_ok, ex_valid;
  logic                stall;
  logic [LANES*SW-1:0] ex_fwd_a, ex_fwd_b;

  fwd_scoreboard_unit #(.LANES(LANES), .STAGES(3), .RB(RB)) dut (
    .clk(clk), .reset(reset),
    .id_valid(v), .id_rs({rs[1], rs[0]}), .id_rt({rt[1], rt[0]}), .id_rd({rd[1], rd[0]}),
    .id_regwrite(rw), .id_memread(mr),
    .pipe_hold(pipe_hold), .flush(flush),
    .issue_ok(issue_ok), .stall(stall),
    .ex_valid(ex_valid), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight producers per stage (1=EX, 2=MEM) and lane.
  logic       m_v  [1:2][0:1];
  logic [4:0] m_rd [1:2][0:1];
  logic       m_ld [1:2][0:1];
  logic [1:0] e_iok;
  logic       e_stall;
  int         e_fa [2];
  int         e_fb [2];
  logic [1:0] x_v;
  int         x_fa [2];
  int         x_fb [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fcode(input logic [4:0] src);
    if (src == 0) return 0;
    for (int s = 1; s <= 2; s++)
      for (int l = 1; l >= 0; l--)
        if (m_v[s][l] && m_rd[s][l] == src) return (s-1)*LANES + l + 1;
    return 0;
  endfunction

  function automatic logic uses(input int i, input logic [4:0] r);
    return (r != 0) && ((rs[i] == r) || (rt[i] == r));
  endfunction

  function automatic logic haz(input int i);
    logic h = 1'b0;
    for (int l = 0; l < 2; l++)
      if (m_v[1][l] && m_ld[1][l] && uses(i, m_rd[1][l])) h = 1'b1;
    for (int j = 0; j < i; j++)
      if (v[j] && rw[j] && rd[j] != 0 && uses(i, rd[j])) h = 1'b1;
    return v[i] && h;
  endfunction

  task automatic model_comb();
    logic blocked = 1'b0;
    e_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (haz(i)) blocked = 1'b1;
      e_iok[i] = v[i] && !pipe_hold && !blocked;
      if (v[i] && blocked) e_stall = 1'b1;
      e_fa[i] = fcode(rs[i]);
      e_fb[i] = fcode(rt[i]);
    end
  endtask

  task automatic model_clear();
    for (int s = 1; s <= 2; s++)
      for (int l = 0; l < 2; l++) begin
        m_v[s][l] = 1'b0; m_rd[s][l] = '0; m_ld[s][l] = 1'b0;
      end
    x_v = '0;
    for (int l = 0; l < 2; l++) begin x_fa[l] = 0; x_fb[l] = 0; end
  endtask

  task automatic model_clock();
    if (reset) model_clear();
    else if (!pipe_hold) begin
      for (int l = 0; l < 2; l++) begin
        m_v[2][l] = m_v[1][l]; m_rd[2][l] = m_rd[1][l]; m_ld[2][l] = m_ld[1][l];
      end
      for (int l = 0; l < 2; l++) begin
        m_v[1][l]  = e_iok[l] && !flush && rw[l] && rd[l] != 0;
        m_rd[1][l] = rd[l];
        m_ld[1][l] = mr[l];
        x_v[l]     = e_iok[l] && !flush;
        x_fa[l]    = x_v[l] ? e_fa[l] : 0;
        x_fb[l]    = x_v[l] ? e_fb[l] : 0;
      end
    end
  endtask

  // One cycle: check everything against the model at the falling edge,
  // then advance the model alongside the DUT's rising edge.
  task automatic step();
    @(negedge clk);
    model_comb();
    chk("issue_ok", 32'(issue_ok), 32'(e_iok));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("ex_valid", 32'(ex_valid), 32'(x_v));
    for (int l = 0; l < 2; l++) begin
      chk("ex_fwd_a", 32'(ex_fwd_a[l*SW +: SW]), x_fa[l]);
      chk("ex_fwd_b", 32'(ex_fwd_b[l*SW +: SW]), x_fb[l]);
    end
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    v = '0; rw = '0; mr = '0; pipe_hold = 1'b0; flush = 1'b0;
    for (int l = 0; l < 2; l++) begin rs[l] = '0; rt[l] = '0; rd[l] = '0; end
  endtask

  task automatic setl(input int l, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic w, input logic m);
    v[l] = 1'b1; rs[l] = a; rt[l] = b; rd[l] = d; rw[l] = w; mr[l] = m;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("reset_ex_valid", 32'(ex_valid), 0);
    chk("reset_fwd", 32'({ex_fwd_a, ex_fwd_b}), 0);

    // ALU producer in T1 forwards code 1 to its consumer.
    clr_in(); setl(0, 0, 0, 5, 1, 0); step();
    clr_in(); setl(0, 5, 0, 0, 0, 0); #1;
    chk("alu_issue", 32'(issue_ok), 32'h1);
    chk("alu_stall", 32'(stall), 0);
    step();
    chk("alu_fwd", 32'(ex_fwd_a[2:0]), 1);

    // Two producers of r7: the younger (T1 lane1) wins; r0 never forwards.
    clr_in(); setl(0, 0, 0, 7, 1, 0); step();
    clr_in(); setl(0, 0, 0, 0, 1, 0); setl(1, 0, 0, 7, 1, 0); step();
    clr_in(); setl(0, 0, 7, 0, 0, 0); step();
    chk("young_fwd_b", 32'(ex_fwd_b[2:0]), 2);
    chk("r0_fwd_a", 32'(ex_fwd_a[2:0]), 0);

    // Load-use: one bubble, then forward from T2 lane0.
    clr_in(); setl(0, 0, 0, 9, 1, 1); step();
    clr_in(); setl(0, 9, 0, 0, 0, 0); #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_issue", 32'(issue_ok), 0);
    step(); #1;
    chk("lu_retry", 32'(issue_ok), 32'h1);
    step();
    chk("lu_fwd", 32'(ex_fwd_a[2:0]), LANES + 1);

    // Intra-bundle RAW splits the bundle; re-presented lane forwards code 1.
    clr_in(); setl(0, 0, 0, 3, 1, 0); setl(1, 3, 0, 0, 0, 0); #1;
    chk("split_issue", 32'(issue_ok), 32'h1);
    chk("split_stall", 32'(stall), 1);
    step();
    clr_in(); setl(1, 3, 0, 0, 0, 0); step();
    chk("split_fwd", 32'(ex_fwd_a[5:3]), 1);

    // Flush squashes the producer.
    clr_in(); setl(0, 0, 0, 11, 1, 0); flush = 1'b1; step();
    chk("flush_valid", 32'(ex_valid), 0);
    clr_in(); setl(0, 11, 0, 0, 0, 0); step();
    chk("flush_fwd", 32'(ex_fwd_a[2:0]), 0);

    // Hold freezes everything for three cycles.
    clr_in(); setl(0, 0, 0, 12, 1, 0); step();
    clr_in(); setl(0, 12, 0, 0, 0, 0); pipe_hold = 1'b1;
    repeat (3) begin #1; chk("hold_issue", 32'(issue_ok), 0); step(); end
    pipe_hold = 1'b0; step();
    chk("hold_fwd", 32'(ex_fwd_a[2:0]), 1);

    // Reset mid-stream discards T1/T2 producers.
    clr_in(); setl(0, 0, 0, 13, 1, 0); step();
    clr_in(); setl(1, 0, 0, 14, 1, 0); step();
    clr_in(); reset = 1'b1; step(); reset = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    clr_in(); setl(0, 13, 14, 0, 0, 0); step();
    chk("rst_fwd", 32'({ex_fwd_a[2:0], ex_fwd_b[2:0]}), 0);

    // Randomised traffic on a small register set to provoke matches.
    for (int n = 0; n < 600; n++) begin
      for (int l = 0; l < 2; l++) begin
        v[l]  = ($urandom_range(0, 9) != 0);
        rs[l] = 5'($urandom_range(0, 3));
        rt[l] = 5'($urandom_range(0, 3));
        rd[l] = 5'($urandom_range(0, 3));
        rw[l] = ($urandom_range(0, 3) != 0);
        mr[l] = ($urandom_range(0, 2) == 0);
      end
      pipe_hold = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Parametrised, sequential successor to the single-lane EX/MEM / MEM/WB forwarding unit, for the superscalar pipeline.
- Tracks destination tags of in-flight instructions for LANES issue lanes across STAGES pipeline stages.
- Produces registered per-lane operand-forward selects aligned with the bundle entering EX.
- Generates load-use stalls and intra-bundle split-issue masks; supports pipeline hold and flush.

Parameters:
LANES, 2, issue width; lane 0 is oldest in a bundle.
STAGES, 3, tracked stages after ID (T1=EX, T2=MEM, T3=WB); must be >= 2.
RB, 5, register index width.
SW, $clog2((STAGES-1)*LANES+1), forward-select width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  LANES  lane holds a valid instruction in ID
id_rs  in  LANES*RB  source A index per lane (lane i at [i*RB +: RB])
id_rt  in  LANES*RB  source B index per lane
id_rd  in  LANES*RB  destination index per lane
id_regwrite  in  LANES  lane writes id_rd
id_memread  in  LANES  lane is a load
pipe_hold  in  1  freeze tracker and EX outputs
flush  in  1  squash the bundle issuing this cycle
issue_ok  out  LANES  combinational; lane issues this cycle
stall  out  1  combinational; any valid lane blocked by hazard
ex_valid  out  LANES  registered; lane valid in EX
ex_fwd_a  out  LANES*SW  registered forward select for source A
ex_fwd_b  out  LANES*SW  registered forward select for source B

Behaviour:
- Reset: all tracker entries invalid; ex_valid=0; ex_fwd_a=ex_fwd_b=0. Reset mid-operation discards all tracked state the same cycle.
- Tracker entry T[s][l] = {valid, rd, load}. An entry is valid only if the lane issued with regwrite=1 and rd!=0.
- Advance when pipe_hold=0:
  - T1 <= issuing lanes, with all entries cleared if flush=1.
  - T[s+1] <= T[s].
  - T[STAGES] is dropped; the register file is write-first, so no forward is needed from it.
- pipe_hold=1: tracker, ex_valid and ex_fwd hold their values; issue_ok=0; flush is ignored and must be held by its source.
- Match rule: source index != 0, equal to a valid entry's rd. Register 0 never matches or forwards.
- Forward code at issue: search T1..T[STAGES-1].
  - Code = (s-1)*LANES + l + 1, where 0 = register file.
  - Priority: lowest s (youngest) first; within a stage, highest l (younger).
  - Codes are registered into ex_fwd_* one cycle later, aligned with EX.
  - With LANES=1, STAGES=3: 1 = EX/MEM, 2 = MEM/WB.
- Hazard for lane i:
  - (a) Load-use: a source matches a T1 entry with load=1.
  - (b) Intra-bundle RAW: a source matches id_rd of a lane j<i with id_valid, regwrite and rd!=0.
- issue_ok[i] = id_valid[i] & !pipe_hold & no hazard in lanes 0..i (prefix mask). Younger lanes never bypass a blocked older lane.
- stall = OR over i of (id_valid[i] & hazard in lanes 0..i), independent of pipe_hold. Upstream re-presents unissued lanes next cycle.
- ex_valid[i] <= issue_ok[i] & !flush. Lanes that do not issue have their ex_fwd forced to 0.
- Load-use costs exactly one bubble: the load moves to T2, and the retry forwards code LANES+l+1.
- RB, LANES and STAGES are fully generic; no hard-coded 5-bit compares.

Test Plan:
- LANES=1: T1 holds rd=5 (ALU op), ID rs=5 -> issue_ok=1, stall=0; next cycle ex_fwd_a=1, ex_valid=1.
- T1 rd=7 and T2 rd=7 both valid, ID rt=7 -> ex_fwd_b selects T1 (code 1 or 2 by lane, never the T2 code); rd=0 producer with ID rs=0 -> ex_fwd_a=0.
- T1 holds a load with rd=9, ID rs=9 -> stall=1, issue_ok=0 for one cycle; next cycle issue_ok=1, then ex_fwd_a=LANES+1 (lane 0 load).
- LANES=2 bundle: lane0 rd=3 regwrite, lane1 rs=3 -> issue_ok=01, stall=1; re-present lane1 alone -> forwards code 1 (T1 lane0).
- Issue with flush=1 -> ex_valid=0 next cycle, and a following consumer of that rd gets code 0. pipe_hold=1 for 3 cycles -> ex outputs and tracker unchanged, issue_ok=0.
- Assert reset mid-stream with valid T1/T2 entries -> next cycle all ex outputs 0, and a matching consumer forwards 0.
